axil_intr_responder: RTL
========================

AXIL_INTR_RESPONDER -- requirements
Module: axil_intr_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, AXI4-Lite address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter C_NUM_OF_INTR, default 1, number of interrupt sources, legal range 1..32.
REQ-004 SHALL have parameter C_IRQ_ACTIVE_STATE, default 1, polarity of irq.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- ACLK, in, 1, single clock.
- ARESET, in, 1, reset, synchronous to ACLK, active-high.
- S_AXI_AWADDR/AWPROT/AWVALID, in, ADDR/3/1, write address channel; AWREADY, out, 1.
- S_AXI_WDATA/WSTRB/WVALID, in, 32/4/1, write data channel; WREADY, out, 1.
- S_AXI_BRESP, out, 2; BVALID, out, 1; BREADY, in, 1.
- S_AXI_ARADDR/ARPROT/ARVALID, in, ADDR/3/1; ARREADY, out, 1.
- S_AXI_RDATA, out, 32; RRESP, out, 2; RVALID, out, 1; RREADY, in, 1.
- intr_src, in, C_NUM_OF_INTR, interrupt source lines, synchronous to ACLK.
- irq, out, 1, combined interrupt to the PS.

Function
REQ-006 Register map, word-decoded on ADDR[4:2]: 0x00 GIE[0] RW; 0x04 IER[N-1:0] RW; 0x08 ISR[N-1:0] RO raw status; 0x0C IAR W1C ack, reads 0; 0x10 IPR = ISR & IER, RO.
REQ-007 Write: AWREADY and WREADY SHALL pulse together for one cycle when AWVALID && WVALID && !BVALID; the register updates on that edge; BVALID rises the next cycle.
REQ-008 BVALID SHALL hold until BREADY; no new write SHALL be accepted while BVALID=1.
REQ-009 Read: ARREADY SHALL pulse for one cycle when ARVALID && !RVALID; RDATA/RVALID SHALL be registered on the next edge; RDATA SHALL be stable while RVALID && !RREADY.
REQ-010 BRESP and RRESP SHALL always be 2'b00 (OKAY); unmapped offsets SHALL read 0, and writes to them SHALL be ignored.
REQ-011 WSTRB[k] SHALL gate byte k on RW registers and on IAR.
REQ-012 ISR bit i SHALL set on a source event for i and clear when IAR bit i is written 1; a simultaneous set and clear SHALL leave the bit set.
REQ-013 irq SHALL be registered: irq = C_IRQ_ACTIVE_STATE when GIE && |IPR, else the inverse; latency is one cycle from the ISR/IER/GIE change.
REQ-014 ISR sets SHALL occur regardless of IER and GIE; IER masks only IPR and irq.
REQ-015 A simultaneous read and write SHALL both proceed; the read SHALL return the pre-write value.
REQ-016 Bits above C_NUM_OF_INTR-1 SHALL read 0.

Reset
REQ-017 While ARESET=1 at a rising edge: GIE, IER, ISR = 0; AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; RDATA = 0; irq = inactive level; edge-detect history = 0.
REQ-018 Reset mid-transaction SHALL drop any outstanding BVALID/RVALID without completing it.

Configuration
REQ-019 Macro INTR_EDGE_DETECT_EN: when defined, a source event is a 0->1 transition of intr_src[i], sampled against a one-cycle-delayed copy; when undefined, a source event is intr_src[i]==1 on any cycle (level), so the ISR bit re-sets after ack while the source is held high.

Structure
REQ-020 Package axil_intr_pkg SHALL hold register offset constants, the OKAY response constant, and the maximum source count.
REQ-021 Sub-module intr_src_detect SHALL implement the per-source event detection and contain the INTR_EDGE_DETECT_EN logic.

Verification
REQ-022 Reset, then read 0x00..0x10 -> all 0, RRESP=0, irq inactive.
REQ-023 Write GIE=1 and IER=1, pulse intr_src[0] -> irq active 1-2 cycles after the pulse; reading 0x10 returns 0x1.
REQ-024 Write IAR=0x1 -> read 0x10 returns 0; irq inactive one cycle after the write commits (edge build); in the level build with the source still high, 0x10 re-reads 0x1.
REQ-025 Source asserted with IER=0 -> ISR reads 0x1, IPR reads 0, irq stays inactive; then write IER=1 -> irq active.
REQ-026 Hold BREADY=0 for 5 cycles while a second AW/W is presented -> BVALID stays high, AWREADY stays 0, second write is accepted after BREADY.
REQ-027 Assert ARESET during an outstanding read with RREADY=0 -> RVALID=0 on the next cycle and all registers read 0.

Source files
------------

// File: rtl/axil_intr_pkg.sv
// Shared constants for the AXI4-Lite interrupt responder: register offsets,
// response code and the largest supported number of interrupt sources.
package axil_intr_pkg;

  localparam int MAX_NUM_INTR = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [4:0] ADDR_GIE = 5'h00;
  localparam logic [4:0] ADDR_IER = 5'h04;
  localparam logic [4:0] ADDR_ISR = 5'h08;
  localparam logic [4:0] ADDR_IAR = 5'h0C;
  localparam logic [4:0] ADDR_IPR = 5'h10;

endpackage

// File: rtl/intr_src_detect.sv
// Per-source event detection. Define INTR_EDGE_DETECT_EN for rising-edge
// events; otherwise a source held high raises an event on every cycle.
module intr_src_detect #(
  parameter int N = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] src,
  output logic [N-1:0] src_event
);

`ifdef INTR_EDGE_DETECT_EN
  logic [N-1:0] src_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      src_d <= '0;
    end else begin
      src_d <= src;
    end
  end

  assign src_event = src & ~src_d;
`else
  logic unused_ctrl;

  assign unused_ctrl = clock ^ reset;
  assign src_event   = src;
`endif

endmodule

// File: rtl/axil_intr_responder.sv
// AXI4-Lite slave exposing GIE/IER/ISR/IAR/IPR with a registered combined irq.
// Source event style is selected by INTR_EDGE_DETECT_EN (see intr_src_detect).
module axil_intr_responder
  import axil_intr_pkg::*;
#(
  parameter int   C_S_AXI_ADDR_WIDTH = 5,
  parameter int   C_S_AXI_DATA_WIDTH = 32,
  parameter int   C_NUM_OF_INTR      = 1,
  parameter logic C_IRQ_ACTIVE_STATE = 1'b1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  output logic                            irq
);

  localparam int N  = C_NUM_OF_INTR;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic          aw_ready_q;
  logic          bvalid_q;
  logic          ar_ready_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          gie_q;
  logic [N-1:0]  ier_q;
  logic [N-1:0]  isr_q;
  logic          irq_q;

  logic          wr_fire;
  logic          rd_fire;
  logic [4:0]    wr_off;
  logic [4:0]    rd_off;
  logic [N-1:0]  byte_mask;
  logic [N-1:0]  ack_bits;
  logic [N-1:0]  src_event;
  logic [DW-1:0] rd_mux;
  logic          unused_bits;

  intr_src_detect #(
    .N(N)
  ) u_detect (
    .clock    (ACLK),
    .reset    (ARESET),
    .src      (intr_src),
    .src_event(src_event)
  );

  assign wr_fire = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = ar_ready_q & S_AXI_ARVALID;
  assign wr_off  = {S_AXI_AWADDR[4:2], 2'b00};
  assign rd_off  = {S_AXI_ARADDR[4:2], 2'b00};

  // Each interrupt bit is owned by the write strobe of the byte it lives in.
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < N; i++) begin
      byte_mask[i] = S_AXI_WSTRB[i/8];
    end
  end

  assign ack_bits = (wr_fire && (wr_off == ADDR_IAR)) ? (S_AXI_WDATA[N-1:0] & byte_mask) : '0;

  always_comb begin
    rd_mux = '0;
    case (rd_off)
      ADDR_GIE: rd_mux[0]   = gie_q;
      ADDR_IER: rd_mux[N-1:0] = ier_q;
      ADDR_ISR: rd_mux[N-1:0] = isr_q;
      ADDR_IPR: rd_mux[N-1:0] = isr_q & ier_q;
      default:  rd_mux = '0;
    endcase
  end

  // Ready pulses are one cycle wide; a response still pending blocks the next accept.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      aw_ready_q <= !aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      ar_ready_q <= !ar_ready_q && S_AXI_ARVALID && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // A new event wins over an acknowledge of the same bit in the same cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      gie_q <= 1'b0;
      ier_q <= '0;
      isr_q <= '0;
      irq_q <= ~C_IRQ_ACTIVE_STATE;
    end else begin
      if (wr_fire && (wr_off == ADDR_GIE) && S_AXI_WSTRB[0]) begin
        gie_q <= S_AXI_WDATA[0];
      end
      if (wr_fire && (wr_off == ADDR_IER)) begin
        ier_q <= (ier_q & ~byte_mask) | (S_AXI_WDATA[N-1:0] & byte_mask);
      end
      isr_q <= (isr_q & ~ack_bits) | src_event;
      irq_q <= (gie_q && |(isr_q & ier_q)) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign irq           = irq_q;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA};

endmodule
